event_packetizer: RTL and testbench

//  Upstream feeder of the USB FIFO streamer. Takes single-cycle bus-sniffer

---
 rtl/event_packetizer.sv | 132 +++++++++++++
 tb/tb_event_packetizer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_packetizer.sv
// Event packetizer: timestamps single-cycle bus-sniffer events and serializes
// each into an 8-byte packet on a registered byte port. Events that cannot be
// buffered are counted and later reported in a 3-byte overflow packet.
module event_packetizer #(
  parameter logic [7:0]  HDR_EVT     = 8'hA0,
  parameter logic [7:0]  HDR_OVF     = 8'hAF,
  parameter int unsigned TS_PRESCALE = 1
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        ev_valid,
  input  logic        ev_write,
  input  logic [23:0] ev_addr,
  input  logic [15:0] ev_data,
  input  logic        have_space,
  output logic [7:0]  data,
  output logic        wr,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam int unsigned  PsW   = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(TS_PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StEvt, StOvf} state_e;

  state_e         state_q;
  logic [PsW-1:0] ps_q;
  logic [15:0]    ts_q;
  logic           slot_full_q;
  logic           slot_write_q;
  logic [15:0]    slot_ts_q;
  logic [23:0]    slot_addr_q;
  logic [15:0]    slot_data_q;
  logic [63:0]    shift_q;
  logic [2:0]     idx_q;

  logic idle, strobe, start_ovf, start_evt, accept, drop, last_byte;

  // Decode packet starts and slot accept/drop decisions for this cycle.
  always_comb begin
    idle      = (state_q == StIdle);
    strobe    = capture_en && ev_valid;
    start_ovf = idle && have_space && (drop_cnt != 16'h0000);
    start_evt = idle && have_space && (drop_cnt == 16'h0000) && slot_full_q;
    // The slot may be refilled in the same cycle it is handed to the shifter.
    accept    = strobe && (!slot_full_q || start_evt);
    drop      = strobe && !accept;
    last_byte = ((state_q == StEvt) && (idx_q == 3'd7)) ||
                ((state_q == StOvf) && (idx_q == 3'd2));
  end

  assign busy = !idle || slot_full_q;

  // Timestamp counter advancing once every TS_PRESCALE clocks.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      ps_q <= '0;
      ts_q <= 16'h0000;
    end else if (ps_q == PsMax) begin
      ps_q <= '0;
      ts_q <= ts_q + 16'd1;
    end else begin
      ps_q <= ps_q + 1'b1;
    end
  end

  // One-deep event holding slot.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      slot_full_q  <= 1'b0;
      slot_write_q <= 1'b0;
      slot_ts_q    <= 16'h0000;
      slot_addr_q  <= 24'h000000;
      slot_data_q  <= 16'h0000;
    end else if (accept) begin
      slot_full_q  <= 1'b1;
      slot_write_q <= ev_write;
      slot_ts_q    <= ts_q;
      slot_addr_q  <= ev_addr;
      slot_data_q  <= ev_data;
    end else if (start_evt) begin
      slot_full_q  <= 1'b0;
    end
  end

  // Saturating drop counter; cleared when its value is snapshotted for OVF.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 16'h0000;
    end else if (start_ovf) begin
      drop_cnt <= drop ? 16'h0001 : 16'h0000;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Packet FSM with registered byte outputs.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shift_q <= 64'h0;
      idx_q   <= 3'd0;
      data    <= 8'h00;
      wr      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wr    <= 1'b0;
          idx_q <= 3'd0;
          if (start_ovf) begin
            state_q <= StOvf;
            shift_q <= {HDR_OVF, drop_cnt, 40'h0};
          end else if (start_evt) begin
            state_q <= StEvt;
            shift_q <= {HDR_EVT | {7'b0, slot_write_q}, slot_ts_q, slot_addr_q, slot_data_q};
          end
        end
        StEvt, StOvf: begin
          wr      <= 1'b1;
          data    <= shift_q[63:56];
          shift_q <= {shift_q[55:0], 8'h00};
          idx_q   <= idx_q + 3'd1;
          if (last_byte) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_event_packetizer.sv
// Randomized scoreboard bench for event_packetizer. A transaction-level model
// tracks the slot, the drop count and when the sender is free, and queues the
// expected bytes with the clock edge at which each must appear.
module tb_event_packetizer;

  localparam logic [7:0]  HdrEvt     = 8'hA0;
  localparam logic [7:0]  HdrOvf     = 8'hAF;
  localparam int unsigned TsPrescale = 1;

  logic        mclk = 1'b0;
  logic        reset;
  logic        capture_en, ev_valid, ev_write, have_space;
  logic [23:0] ev_addr;
  logic [15:0] ev_data;
  logic [7:0]  data;
  logic        wr, busy;
  logic [15:0] drop_cnt;

  event_packetizer #(
    .HDR_EVT    (HdrEvt),
    .HDR_OVF    (HdrOvf),
    .TS_PRESCALE(TsPrescale)
  ) dut (
    .mclk      (mclk),
    .reset     (reset),
    .capture_en(capture_en),
    .ev_valid  (ev_valid),
    .ev_write  (ev_write),
    .ev_addr   (ev_addr),
    .ev_data   (ev_data),
    .have_space(have_space),
    .data      (data),
    .wr        (wr),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] cyc;
  } exp_t;

  // Reference model state (written only by the model process).
  exp_t        exp_q[$];
  int unsigned edge_n;
  int unsigned busy_left;
  bit          m_slot;
  logic        m_w;
  logic [15:0] m_ts, m_d, m_drops;
  logic [23:0] m_a;

  always @(posedge mclk or negedge reset) begin
    if (!reset) begin
      edge_n    = 0;
      busy_left = 0;
      m_slot    = 1'b0;
      m_drops   = 16'h0000;
    end else begin
      logic [15:0] ts_now;
      bit free, s_ovf, s_evt, strobe, acc;
      edge_n++;
      // Timestamp seen at this edge: ticks elapsed over the previous edges.
      ts_now = 16'(((edge_n - 1) / TsPrescale) % 65536);
      free   = (busy_left == 0);
      s_ovf  = free && have_space && (m_drops != 16'h0000);
      s_evt  = free && have_space && (m_drops == 16'h0000) && m_slot;
      strobe = capture_en && ev_valid;
      acc    = strobe && (!m_slot || s_evt);
      if (s_ovf) begin
        exp_q.push_back('{b: HdrOvf,        cyc: edge_n + 1});
        exp_q.push_back('{b: m_drops[15:8], cyc: edge_n + 2});
        exp_q.push_back('{b: m_drops[7:0],  cyc: edge_n + 3});
        busy_left = 3;
        m_drops   = 16'h0000;
      end else if (s_evt) begin
        exp_q.push_back('{b: HdrEvt | {7'b0, m_w}, cyc: edge_n + 1});
        exp_q.push_back('{b: m_ts[15:8],  cyc: edge_n + 2});
        exp_q.push_back('{b: m_ts[7:0],   cyc: edge_n + 3});
        exp_q.push_back('{b: m_a[23:16],  cyc: edge_n + 4});
        exp_q.push_back('{b: m_a[15:8],   cyc: edge_n + 5});
        exp_q.push_back('{b: m_a[7:0],    cyc: edge_n + 6});
        exp_q.push_back('{b: m_d[15:8],   cyc: edge_n + 7});
        exp_q.push_back('{b: m_d[7:0],    cyc: edge_n + 8});
        busy_left = 8;
        m_slot    = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (strobe && !acc && (m_drops != 16'hFFFF)) m_drops++;
      if (acc) begin
        m_slot = 1'b1;
        m_w    = ev_write;
        m_ts   = ts_now;
        m_a    = ev_addr;
        m_d    = ev_data;
      end
    end
  end

  // Monitor / scoreboard (sole owner of the check counters).
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rd_idx = 0;
  logic [7:0]  last_data = 8'h00;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  always @(negedge mclk) begin
    if (!reset) begin
      chk("reset_wr", {31'b0, wr}, 32'd0);
      chk("reset_data", {24'b0, data}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_drop_cnt", {16'b0, drop_cnt}, 32'd0);
      rd_idx    = exp_q.size();
      last_data = 8'h00;
    end else begin
      if (wr) begin
        if (rd_idx < exp_q.size()) begin
          chk("byte_value", {24'b0, data}, {24'b0, exp_q[rd_idx].b});
          chk("byte_cycle", edge_n, exp_q[rd_idx].cyc);
          rd_idx++;
        end else begin
          chk("unexpected_wr", {31'b0, wr}, 32'd0);
        end
      end else begin
        chk("data_hold", {24'b0, data}, {24'b0, last_data});
        if ((rd_idx < exp_q.size()) && (exp_q[rd_idx].cyc <= edge_n)) begin
          chk("missing_wr", {31'b0, wr}, 32'd1);
          rd_idx++;
        end
      end
      last_data = data;
      chk("drop_cnt", {16'b0, drop_cnt}, {16'b0, m_drops});
      chk("busy", {31'b0, busy}, {31'b0, (busy_left != 0) || m_slot});
    end
    if (done) begin
      chk("queue_drained", rd_idx, exp_q.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic strobe_ev(input logic w, input logic [23:0] a, input logic [15:0] d);
    ev_valid = 1'b1;
    ev_write = w;
    ev_addr  = a;
    ev_data  = d;
    tick();
    ev_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    capture_en = 1'b1;
    ev_valid   = 1'b0;
    ev_write   = 1'b0;
    ev_addr    = 24'h0;
    ev_data    = 16'h0;
    have_space = 1'b1;
    #22 reset = 1'b1;
    tick();

    // Single write event sampled with ts=0010.
    while (edge_n < 16) tick();
    strobe_ev(1'b1, 24'h123456, 16'hBEEF);
    repeat (15) tick();

    // Three consecutive strobes: two packed, third dropped.
    strobe_ev(1'b0, 24'hA1B2C3, 16'h1111);
    strobe_ev(1'b1, 24'hD4E5F6, 16'h2222);
    strobe_ev(1'b0, 24'h0F0F0F, 16'h3333);
    repeat (30) tick();

    // Randomized traffic with backpressure and capture gating.
    for (int i = 0; i < 2000; i++) begin
      ev_valid   = ($urandom_range(0, 2) == 0);
      capture_en = ($urandom_range(0, 7) != 0);
      have_space = ($urandom_range(0, 3) != 0);
      ev_write   = 1'($urandom);
      ev_addr    = 24'($urandom);
      ev_data    = 16'($urandom);
      tick();
    end
    ev_valid   = 1'b0;
    capture_en = 1'b1;
    have_space = 1'b1;
    repeat (30) tick();

    // No space for 100 cycles with 5 strobes.
    have_space = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 20 == 10) strobe_ev(1'($urandom), 24'($urandom), 16'($urandom));
      else tick();
    end
    have_space = 1'b1;
    repeat (30) tick();

    // Reset during EVT byte 3.
    strobe_ev(1'b1, 24'hCAFE01, 16'h5A5A);
    for (int k = 0; k < 20 && !wr; k++) tick();
    repeat (3) tick();
    #1 reset = 1'b0;
    repeat (3) tick();
    #3 reset = 1'b1;
    repeat (20) tick();
    while (edge_n < 5) tick();
    strobe_ev(1'b0, 24'h00BEEF, 16'h0042);
    repeat (20) tick();

    // Saturate the drop counter and let the timestamp wrap.
    have_space = 1'b0;
    strobe_ev(1'b1, 24'h777777, 16'h8888);
    ev_valid = 1'b1;
    repeat (66000) tick();
    ev_valid   = 1'b0;
    have_space = 1'b1;
    repeat (30) tick();
    strobe_ev(1'b0, 24'h010203, 16'h0405);
    repeat (30) tick();

    done = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor did not finish");
    $fatal(1);
  end

endmodule
